tune_seq: RTL and testbench



---
 rtl/tune_seq.sv | 182 ++++++++++++++++++
 tb/tb_tune_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tune_seq.sv
// Programmable piezo tune sequencer: plays a writable table of {period, 2^dur}
// notes once or looping on a differential piezo pair, with rests, gaps and abort.
module tune_seq #(
  parameter int FAST_SIM  = 1,
  parameter int NUM_NOTES = 8,
  parameter int PER_W     = 16,
  parameter int GAP_CYC   = 0,
  localparam int AW       = $clog2(NUM_NOTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PER_W-1:0] wr_period,
  input  logic [4:0]       wr_dur,
  input  logic             go,
  input  logic [AW:0]      len,
  input  logic             loop,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_idx,
  output logic             piezo,
  output logic             piezo_n
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [32:0] INC = (FAST_SIM != 0) ? 33'd16 : 33'd1;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(NUM_NOTES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, GAP = 2'd2} state_t;

  logic [PER_W-1:0] period_mem [NUM_NOTES];
  logic [4:0]       dur_mem    [NUM_NOTES];

  state_t           state_r, state_nx;
  logic [AW-1:0]    idx_r, idx_nx, adv_idx_s;
  logic [PER_W-1:0] phase_r, phase_nx, phase_step_s;
  logic [31:0]      dur_r, dur_nx;
  logic [GW-1:0]    gap_r, gap_nx;
  logic [AW:0]      len_r, len_nx;
  logic             loop_r, loop_nx;
  logic             busy_r, done_r, done_nx, piezo_r, piezo_n_r;
  logic [PER_W-1:0] cur_per_s, nx_per_s;
  logic [4:0]       cur_dur_s;
  logic             note_end_s, is_last_s, tone_on_s, high_half_s;

  // Note table: written only while idle, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        period_mem[i] <= PER_W'(0);
        dur_mem[i]    <= 5'd0;
      end
    end else if (wr_en && !busy_r) begin
      period_mem[wr_addr] <= wr_period;
      dur_mem[wr_addr]    <= wr_dur;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_nx  = state_r;
    idx_nx    = idx_r;
    phase_nx  = phase_r;
    dur_nx    = dur_r;
    gap_nx    = gap_r;
    len_nx    = len_r;
    loop_nx   = loop_r;
    done_nx   = 1'b0;
    cur_per_s = period_mem[idx_r];
    cur_dur_s = dur_mem[idx_r];
    note_end_s = ({1'b0, dur_r} + INC) >= (33'd1 << cur_dur_s);
    is_last_s  = ({1'b0, idx_r} + (AW+1)'(1)) == len_r;
    adv_idx_s  = is_last_s ? AW'(0) : idx_r + AW'(1);
    if (cur_per_s == PER_W'(0)) begin
      phase_step_s = PER_W'(0);
    end else if (({1'b0, phase_r} + (PER_W+1)'(1)) >= {1'b0, cur_per_s}) begin
      phase_step_s = PER_W'(0);
    end else begin
      phase_step_s = phase_r + PER_W'(1);
    end

    case (state_r)
      IDLE: begin
        if (go && (len != (AW+1)'(0)) && (len <= LEN_MAX)) begin
          state_nx = TONE;
          idx_nx   = AW'(0);
          phase_nx = PER_W'(0);
          dur_nx   = 32'd0;
          gap_nx   = GW'(0);
          len_nx   = len;
          loop_nx  = loop;
        end else begin
          state_nx = IDLE;
        end
      end
      TONE: begin
        if (abort) begin
          state_nx = IDLE;
          idx_nx   = AW'(0);
        end else if (note_end_s) begin
          phase_nx = PER_W'(0);
          dur_nx   = 32'd0;
          if (is_last_s && !loop_r) begin
            state_nx = IDLE;
            idx_nx   = AW'(0);
            done_nx  = 1'b1;
          end else if (GAP_CYC > 0) begin
            state_nx = GAP;
            gap_nx   = GW'(0);
          end else begin
            idx_nx = adv_idx_s;
          end
        end else begin
          dur_nx   = dur_r + INC[31:0];
          phase_nx = phase_step_s;
        end
      end
      GAP: begin
        if (abort) begin
          state_nx = IDLE;
          idx_nx   = AW'(0);
        end else if (gap_r == GAP_LAST) begin
          state_nx = TONE;
          idx_nx   = adv_idx_s;
          phase_nx = PER_W'(0);
          dur_nx   = 32'd0;
        end else begin
          gap_nx = gap_r + GW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = AW'(0);
      end
    endcase

    // Drive levels are registered from the upcoming note/phase so the first
    // tone edge lands on the same cycle busy rises.
    nx_per_s    = period_mem[idx_nx];
    tone_on_s   = (state_nx == TONE) && (nx_per_s != PER_W'(0));
    high_half_s = phase_nx < (nx_per_s >> 1);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= AW'(0);
      phase_r   <= PER_W'(0);
      dur_r     <= 32'd0;
      gap_r     <= GW'(0);
      len_r     <= (AW+1)'(0);
      loop_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      piezo_r   <= 1'b0;
      piezo_n_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      idx_r     <= idx_nx;
      phase_r   <= phase_nx;
      dur_r     <= dur_nx;
      gap_r     <= gap_nx;
      len_r     <= len_nx;
      loop_r    <= loop_nx;
      busy_r    <= (state_nx != IDLE);
      done_r    <= done_nx;
      piezo_r   <= tone_on_s && high_half_s;
      piezo_n_r <= tone_on_s && !high_half_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign cur_idx = idx_r;
  assign piezo   = piezo_r;
  assign piezo_n = piezo_n_r;

endmodule

// File: tb/tb_tune_seq.sv
// Scoreboard bench for tune_seq: three builds (fast, fast+gap, slow) share the
// write/len/loop/abort inputs; per-build queues hold hand-computed output traces.
module tb_tune_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_period = 16'd0;
  logic [4:0]  wr_dur = 5'd0;
  logic [3:0]  len = 4'd0;
  logic        loop = 1'b0;
  logic        abort = 1'b0;
  logic        wr_en_a [3];
  logic        go_a    [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic [2:0]  idx_a   [3];
  logic        pz_a    [3];
  logic        pzn_a   [3];

  typedef struct packed {
    logic       done;
    logic [2:0] idx;
    logic       pz;
    logic       pzn;
  } exp_t;

  exp_t exp_q [3][$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  tune_seq #(.FAST_SIM(1), .NUM_NOTES(8), .PER_W(16), .GAP_CYC(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a[0]), .wr_addr(wr_addr), .wr_period(wr_period),
    .wr_dur(wr_dur), .go(go_a[0]), .len(len), .loop(loop), .abort(abort), .busy(busy_a[0]),
    .done(done_a[0]), .cur_idx(idx_a[0]), .piezo(pz_a[0]), .piezo_n(pzn_a[0]));

  tune_seq #(.FAST_SIM(1), .NUM_NOTES(8), .PER_W(16), .GAP_CYC(3)) u_gap (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a[1]), .wr_addr(wr_addr), .wr_period(wr_period),
    .wr_dur(wr_dur), .go(go_a[1]), .len(len), .loop(loop), .abort(abort), .busy(busy_a[1]),
    .done(done_a[1]), .cur_idx(idx_a[1]), .piezo(pz_a[1]), .piezo_n(pzn_a[1]));

  tune_seq #(.FAST_SIM(0), .NUM_NOTES(8), .PER_W(16), .GAP_CYC(0)) u_slow (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a[2]), .wr_addr(wr_addr), .wr_period(wr_period),
    .wr_dur(wr_dur), .go(go_a[2]), .len(len), .loop(loop), .abort(abort), .busy(busy_a[2]),
    .done(done_a[2]), .cur_idx(idx_a[2]), .piezo(pz_a[2]), .piezo_n(pzn_a[2]));

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: every busy/done cycle pops one expected entry; idle cycles must be silent
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (busy_a[k] || done_a[k]) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("unexpected_output_dut%0d", k), {30'd0, busy_a[k], done_a[k]}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q[k].pop_front();
          check($sformatf("trace_dut%0d", k),
                {26'd0, done_a[k], idx_a[k], pz_a[k], pzn_a[k]}, {26'd0, e});
        end
      end else begin
        check($sformatf("idle_silent_dut%0d", k), {30'd0, pz_a[k], pzn_a[k]}, 32'd0);
      end
    end
  end

  task automatic push(int k, int n, logic d, logic [2:0] i, logic p, logic pn);
    exp_t e;
    e.done = d; e.idx = i; e.pz = p; e.pzn = pn;
    repeat (n) exp_q[k].push_back(e);
  endtask

  task automatic wr(int k, logic [2:0] a, logic [15:0] p, logic [4:0] d);
    @(negedge clk);
    wr_en_a[k] = 1'b1; wr_addr = a; wr_period = p; wr_dur = d;
    @(negedge clk);
    wr_en_a[k] = 1'b0;
  endtask

  task automatic start(int k, logic [3:0] l, logic lp, logic want_busy);
    @(negedge clk);
    go_a[k] = 1'b1; len = l; loop = lp;
    @(negedge clk);
    go_a[k] = 1'b0;
    check($sformatf("busy_after_go_dut%0d_len%0d", k, l), {31'd0, busy_a[k]}, {31'd0, want_busy});
  endtask

  task automatic wait_idle(int k);
    int i;
    i = 0;
    while (busy_a[k] && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (busy_a[k]) check($sformatf("wait_idle_timeout_dut%0d", k), {31'd0, busy_a[k]}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      wr_en_a[k] = 1'b0;
      go_a[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_outputs_dut%0d", k),
            {25'd0, busy_a[k], done_a[k], idx_a[k], pz_a[k], pzn_a[k]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single note {8,6}: four high cycles, then done
    wr(0, 3'd0, 16'd8, 5'd6);
    push(0, 4, 1'b0, 3'd0, 1'b1, 1'b0);
    push(0, 1, 1'b1, 3'd0, 1'b0, 1'b0);
    start(0, 4'd1, 1'b0, 1'b1);
    wait_idle(0);

    // Three notes including a rest
    wr(0, 3'd0, 16'd10, 5'd5);
    wr(0, 3'd1, 16'd0, 5'd5);
    wr(0, 3'd2, 16'd6, 5'd4);
    push(0, 2, 1'b0, 3'd0, 1'b1, 1'b0);
    push(0, 2, 1'b0, 3'd1, 1'b0, 1'b0);
    push(0, 1, 1'b0, 3'd2, 1'b1, 1'b0);
    push(0, 1, 1'b1, 3'd0, 1'b0, 1'b0);
    start(0, 4'd3, 1'b0, 1'b1);
    wait_idle(0);

    // Looping, aborted during note 2 of the third pass
    for (int p = 0; p < 3; p++) begin
      push(0, 2, 1'b0, 3'd0, 1'b1, 1'b0);
      push(0, 2, 1'b0, 3'd1, 1'b0, 1'b0);
      push(0, 1, 1'b0, 3'd2, 1'b1, 1'b0);
    end
    start(0, 4'd3, 1'b1, 1'b1);
    repeat (14) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_done", {30'd0, busy_a[0], done_a[0]}, 32'd0);
    check("abort_piezo", {30'd0, pz_a[0], pzn_a[0]}, 32'd0);
    repeat (3) @(negedge clk);

    // Write and go during playback are both ignored
    push(0, 2, 1'b0, 3'd0, 1'b1, 1'b0);
    push(0, 2, 1'b0, 3'd1, 1'b0, 1'b0);
    push(0, 1, 1'b0, 3'd2, 1'b1, 1'b0);
    push(0, 1, 1'b1, 3'd0, 1'b0, 1'b0);
    start(0, 4'd3, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    wr_en_a[0] = 1'b1; wr_addr = 3'd0; wr_period = 16'd2; wr_dur = 5'd0;
    go_a[0] = 1'b1; len = 4'd3;
    @(negedge clk);
    wr_en_a[0] = 1'b0; go_a[0] = 1'b0;
    wait_idle(0);
    push(0, 2, 1'b0, 3'd0, 1'b1, 1'b0);
    push(0, 1, 1'b1, 3'd0, 1'b0, 1'b0);
    start(0, 4'd1, 1'b0, 1'b1);
    wait_idle(0);

    // Out-of-range lengths never start
    start(0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    start(0, 4'd9, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // P=1 with D=0: a single low cycle
    wr(0, 3'd0, 16'd1, 5'd0);
    push(0, 1, 1'b0, 3'd0, 1'b0, 1'b1);
    push(0, 1, 1'b1, 3'd0, 1'b0, 1'b0);
    start(0, 4'd1, 1'b0, 1'b1);
    wait_idle(0);

    // Gap build: three silent cycles between two notes
    wr(1, 3'd0, 16'd4, 5'd5);
    wr(1, 3'd1, 16'd2, 5'd5);
    push(1, 2, 1'b0, 3'd0, 1'b1, 1'b0);
    push(1, 3, 1'b0, 3'd0, 1'b0, 1'b0);
    push(1, 1, 1'b0, 3'd1, 1'b1, 1'b0);
    push(1, 1, 1'b0, 3'd1, 1'b0, 1'b1);
    push(1, 1, 1'b1, 3'd0, 1'b0, 1'b0);
    start(1, 4'd2, 1'b0, 1'b1);
    wait_idle(1);

    // Slow build: D=4 lasts 16 cycles, period 4 square wave
    wr(2, 3'd0, 16'd4, 5'd4);
    for (int r = 0; r < 4; r++) begin
      push(2, 2, 1'b0, 3'd0, 1'b1, 1'b0);
      push(2, 2, 1'b0, 3'd0, 1'b0, 1'b1);
    end
    push(2, 1, 1'b1, 3'd0, 1'b0, 1'b0);
    start(2, 4'd1, 1'b0, 1'b1);
    wait_idle(2);

    // Async reset mid-note clears outputs at once and wipes the table
    push(2, 2, 1'b0, 3'd0, 1'b1, 1'b0);
    push(2, 2, 1'b0, 3'd0, 1'b0, 1'b1);
    push(2, 1, 1'b0, 3'd0, 1'b1, 1'b0);
    start(2, 4'd1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {25'd0, busy_a[2], done_a[2], idx_a[2], pz_a[2], pzn_a[2]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(2, 1, 1'b0, 3'd0, 1'b0, 1'b0);
    push(2, 1, 1'b1, 3'd0, 1'b0, 1'b0);
    start(2, 4'd1, 1'b0, 1'b1);
    wait_idle(2);
    repeat (2) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      check($sformatf("trace_drained_dut%0d", k), exp_q[k].size(), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
